sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Owns the single SDRAM command/address/bank bus and shares it between the `sdram_read` and `sdram_write` engines and the periodic auto-refresh sequence. It sits between the wishbone SDRAM top level (host read/write requests, init-done flag) and the two engines. It grants one engine at a time, raises `auto_refresh` on the refresh interval, and issues PRECHARGE-ALL + AUTO REFRESH itself once the owning engine is parked.

## Interface

Parameters:
- `REFRESH_INTERVAL`, 1560: clock cycles between refresh requests (15.6 us at 100 MHz).
- `T_RP`, 2: NOP cycles after PRECHARGE-ALL.
- `T_RFC`, 7: NOP cycles after AUTO REFRESH.

Ports (reset: synchronous, active-high; one clock):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `init_done` in 1: power-up init complete. No grants, refresh timing or commands until high.
- `app_read_req` in 1: host wants reads. Level, held for the whole transfer.
- `app_write_req` in 1: host wants writes. Level.
- `rd_enable` out 1: enable to read engine.
- `rd_idle` in 1: read engine parked (IDLE/WAIT, delay 0).
- `rd_command` in 3, `rd_address` in 12, `rd_bank` in 2: read engine bus.
- `wr_enable` out 1, `wr_idle` in 1, `wr_command` in 3, `wr_address` in 12, `wr_bank` in 2: same for the write engine.
- `auto_refresh` out 1: refresh pending, to both engines.
- `command` out 3, `address` out 12, `bank` out 2: registered SDRAM bus.
- `refresh_overrun` out 1: sticky; an interval expired while a refresh was still pending.

## Operation

- Command encodings come from `sdram_include.v` (`SDRAM_CMD_NOP/PRE/AR`).
- State `state`: IDLE, READ, WRITE, REF_PRE, REF_AR, REF_WAIT.
- Register `owner`: NONE/RD/WR, holding the grant across a refresh.
- Register `last`: last engine served, used for round-robin.
- Refresh timer:
  - Down-counter loaded with `REFRESH_INTERVAL-1`; decrements each cycle while `init_done`.
  - At 0: reload, set `refresh_pending`. If it is already set, also set `refresh_overrun`.
  - `auto_refresh` = `refresh_pending`. It clears on the cycle the AR command is registered.
- IDLE:
  - If `refresh_pending`: go to REF_PRE.
  - Else if exactly one request is high: grant it.
  - Else if both are high: grant the engine that is not `last`.
  - Grant action: state becomes READ/WRITE, `owner` and `last` updated, that enable asserted.
- READ (WRITE symmetric):
  - `rd_enable` = `app_read_req`. Bus passes `rd_*` through.
  - Exit only when `rd_idle`=1, checked in this priority order:
    1. `refresh_pending`: go to REF_PRE, enable held high so the engine FIFOs are not reset.
    2. `!app_read_req`: go to IDLE, owner NONE.
    3. `app_write_req`: drop `rd_enable`, grant WRITE next cycle.
- REF_PRE: drive PRE with `address[10]`=1, bank 0. Then NOP for `T_RP` cycles, then REF_AR.
- REF_AR: drive AR, clear pending. Then NOP for `T_RFC` cycles, then REF_WAIT.
- REF_WAIT, one cycle:
  - If `owner` still requests: return to READ/WRITE.
  - Else: go to IDLE and drop the enable.
- Both enables are never high together. The non-owner's enable is always 0.
- `init_done`=0 holds: state IDLE, timer loaded, pending 0, enables 0, bus NOP.
- Reset values:
  - `command`=NOP, `address`=0, `bank`=0.
  - `rd_enable`=`wr_enable`=0, `auto_refresh`=0, `refresh_overrun`=0.
  - state IDLE, owner NONE, `last`=WR, so reads win the first tie.
- Reset mid-burst or mid-refresh: everything returns to reset values on the next edge. No command is completed.

## Timing

- Bus latency: `command/address/bank` are registered 1 cycle after the mux input (engine output or internal refresh command).
- Grant: request sampled in IDLE, enable high next cycle. Engine commands appear on the bus 1 cycle after the engine drives them.
- Refresh span, from `rd_idle` seen to the grant restored: 1 (PRE) + `T_RP` + 1 (AR) + `T_RFC` + 1 (REF_WAIT) cycles. That is 12 cycles with defaults.
- Handover between engines: at least 2 cycles of NOP (enable drop, then grant).
- `refresh_pending` is set and a request arrives in the same IDLE cycle: refresh wins.
- Timer expiry and AR on the same cycle: pending is cleared by AR and set by the timer. Net result: set, no overrun.

## Test plan

- Reset with `init_done`=0 for 100 cycles: `command`=NOP, enables 0, `auto_refresh`=0 throughout.
- `REFRESH_INTERVAL`=64, idle host, `init_done` high at cycle 0:
  - `auto_refresh` rises at cycle 64.
  - PRE with `address[10]`=1 on the next bus cycle, AR 3 cycles later, then 7 NOPs.
  - Pending is low after AR.
- `app_read_req` held, `rd_idle` pulsed once every 20 cycles:
  - At refresh, PRE follows the first `rd_idle`. `rd_enable` stays 1 during the whole sequence.
  - Read engine commands resume 12 cycles later.
- `app_read_req` and `app_write_req` both rise in the same cycle:
  - Read granted first.
  - At `rd_idle`, `rd_enable` falls and `wr_enable` rises next cycle.
  - Enables are never high together.
- Hold `rd_idle`=0 for 200 cycles with `REFRESH_INTERVAL`=64: `refresh_overrun` sets at cycle 128 and stays set until `rst`.
- Assert `rst` during REF_AR delay: next cycle bus NOP, state IDLE, `auto_refresh`=0, timer reloaded.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM command/address/bank bus between the read and write engines and
// inserts PRECHARGE-ALL + AUTO REFRESH on the refresh interval once the owner is parked.
module sdram_arbiter #(
   parameter int REFRESH_INTERVAL = 1560,
   parameter int T_RP             = 2,
   parameter int T_RFC            = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        init_done,
   input  logic        app_read_req,
   input  logic        app_write_req,
   output logic        rd_enable,
   input  logic        rd_idle,
   input  logic [2:0]  rd_command,
   input  logic [11:0] rd_address,
   input  logic [1:0]  rd_bank,
   output logic        wr_enable,
   input  logic        wr_idle,
   input  logic [2:0]  wr_command,
   input  logic [11:0] wr_address,
   input  logic [1:0]  wr_bank,
   output logic        auto_refresh,
   output logic [2:0]  command,
   output logic [11:0] address,
   output logic [1:0]  bank,
   output logic        refresh_overrun
);

   localparam logic [2:0] CMD_NOP = 3'b111;
   localparam logic [2:0] CMD_PRE = 3'b010;
   localparam logic [2:0] CMD_AR  = 3'b001;
   localparam int         TW      = $clog2(REFRESH_INTERVAL + 1);
   localparam logic [TW-1:0] TIMER_LOAD = TW'(REFRESH_INTERVAL - 1);
   localparam logic [7:0] RP_LAST  = 8'(T_RP);
   localparam logic [7:0] RFC_LAST = 8'(T_RFC);
   localparam logic       LAST_RD  = 1'b0;
   localparam logic       LAST_WR  = 1'b1;

   typedef enum logic [2:0] {IDLE, READ, WRITE, REF_PRE, REF_AR, REF_WAIT} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_RD, OWN_WR} owner_t;

   state_t        state, state_next;
   owner_t        owner, owner_next;
   logic          last, last_next;
   logic [7:0]    dly, dly_next;
   logic [TW-1:0] timer;
   logic          refresh_pending;
   logic          expire, ar_fire;
   logic [2:0]    cmd_mux;
   logic [11:0]   addr_mux;
   logic [1:0]    bank_mux;

   assign expire       = (timer == '0);
   assign ar_fire      = (state == REF_AR) && (dly == 8'd0);
   assign auto_refresh = refresh_pending;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         owner <= OWN_NONE;
         last  <= LAST_WR;
         dly   <= 8'd0;
      end else begin
         state <= state_next;
         owner <= owner_next;
         last  <= last_next;
         dly   <= dly_next;
      end
   end

   always_comb begin
      state_next = state;
      owner_next = owner;
      last_next  = last;
      dly_next   = dly;
      case (state)
         IDLE: begin
            if (refresh_pending) begin
               state_next = REF_PRE;
               dly_next   = 8'd0;
            end else if (app_read_req && (!app_write_req || last == LAST_WR)) begin
               state_next = READ;
               owner_next = OWN_RD;
               last_next  = LAST_RD;
            end else if (app_write_req) begin
               state_next = WRITE;
               owner_next = OWN_WR;
               last_next  = LAST_WR;
            end
         end
         READ: begin
            if (rd_idle) begin
               if (refresh_pending) begin
                  state_next = REF_PRE;
                  dly_next   = 8'd0;
               end else if (!app_read_req) begin
                  state_next = IDLE;
                  owner_next = OWN_NONE;
               end else if (app_write_req) begin
                  state_next = WRITE;
                  owner_next = OWN_WR;
                  last_next  = LAST_WR;
               end
            end
         end
         WRITE: begin
            if (wr_idle) begin
               if (refresh_pending) begin
                  state_next = REF_PRE;
                  dly_next   = 8'd0;
               end else if (!app_write_req) begin
                  state_next = IDLE;
                  owner_next = OWN_NONE;
               end else if (app_read_req) begin
                  state_next = READ;
                  owner_next = OWN_RD;
                  last_next  = LAST_RD;
               end
            end
         end
         REF_PRE: begin
            if (dly == RP_LAST) begin
               state_next = REF_AR;
               dly_next   = 8'd0;
            end else begin
               dly_next = dly + 8'd1;
            end
         end
         REF_AR: begin
            if (dly == RFC_LAST) begin
               state_next = REF_WAIT;
               dly_next   = 8'd0;
            end else begin
               dly_next = dly + 8'd1;
            end
         end
         REF_WAIT: begin
            if (owner == OWN_RD && app_read_req) begin
               state_next = READ;
            end else if (owner == OWN_WR && app_write_req) begin
               state_next = WRITE;
            end else begin
               state_next = IDLE;
               owner_next = OWN_NONE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (!init_done) begin
         state_next = IDLE;
         owner_next = OWN_NONE;
         dly_next   = 8'd0;
      end
   end

   // During refresh the owner's enable stays high so its FIFOs survive the gap.
   always_comb begin
      rd_enable = 1'b0;
      wr_enable = 1'b0;
      cmd_mux   = CMD_NOP;
      addr_mux  = 12'd0;
      bank_mux  = 2'd0;
      case (state)
         READ: begin
            rd_enable = app_read_req && !(rd_idle && !refresh_pending && app_write_req);
            cmd_mux   = rd_command;
            addr_mux  = rd_address;
            bank_mux  = rd_bank;
         end
         WRITE: begin
            wr_enable = app_write_req && !(wr_idle && !refresh_pending && app_read_req);
            cmd_mux   = wr_command;
            addr_mux  = wr_address;
            bank_mux  = wr_bank;
         end
         REF_PRE: begin
            rd_enable = (owner == OWN_RD);
            wr_enable = (owner == OWN_WR);
            if (dly == 8'd0) begin
               cmd_mux  = CMD_PRE;
               addr_mux = 12'h400;
            end
         end
         REF_AR: begin
            rd_enable = (owner == OWN_RD);
            wr_enable = (owner == OWN_WR);
            if (dly == 8'd0) cmd_mux = CMD_AR;
         end
         REF_WAIT: begin
            rd_enable = (owner == OWN_RD) && app_read_req;
            wr_enable = (owner == OWN_WR) && app_write_req;
         end
         default: ;
      endcase
      if (!init_done) begin
         rd_enable = 1'b0;
         wr_enable = 1'b0;
         cmd_mux   = CMD_NOP;
         addr_mux  = 12'd0;
         bank_mux  = 2'd0;
      end
   end

   // A timer set on the same edge as the AR clear wins, and is not an overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer           <= TIMER_LOAD;
         refresh_pending <= 1'b0;
         refresh_overrun <= 1'b0;
      end else if (!init_done) begin
         timer           <= TIMER_LOAD;
         refresh_pending <= 1'b0;
      end else begin
         timer           <= expire ? TIMER_LOAD : timer - 1'b1;
         refresh_pending <= expire || (refresh_pending && !ar_fire);
         if (expire && refresh_pending && !ar_fire) refresh_overrun <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         command <= CMD_NOP;
         address <= 12'd0;
         bank    <= 2'd0;
      end else begin
         command <= cmd_mux;
         address <= addr_mux;
         bank    <= bank_mux;
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a short refresh interval; expected
// cycle numbers are hand-derived from the arbitration and refresh timing.
module tb_sdram_arbiter;

   localparam logic [2:0] NOP = 3'b111;
   localparam logic [2:0] PRE = 3'b010;
   localparam logic [2:0] AR  = 3'b001;
   localparam logic [2:0] RDC = 3'b101;
   localparam logic [2:0] WRC = 3'b100;

   logic        clk = 1'b0;
   logic        rst, init_done, app_read_req, app_write_req;
   logic        rd_enable, rd_idle, wr_enable, wr_idle;
   logic [2:0]  rd_command, wr_command, command;
   logic [11:0] rd_address, wr_address, address;
   logic [1:0]  rd_bank, wr_bank, bank;
   logic        auto_refresh, refresh_overrun;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sdram_arbiter #(.REFRESH_INTERVAL(64), .T_RP(2), .T_RFC(7)) dut (
      .clk(clk), .rst(rst), .init_done(init_done),
      .app_read_req(app_read_req), .app_write_req(app_write_req),
      .rd_enable(rd_enable), .rd_idle(rd_idle), .rd_command(rd_command),
      .rd_address(rd_address), .rd_bank(rd_bank),
      .wr_enable(wr_enable), .wr_idle(wr_idle), .wr_command(wr_command),
      .wr_address(wr_address), .wr_bank(wr_bank),
      .auto_refresh(auto_refresh), .command(command), .address(address),
      .bank(bank), .refresh_overrun(refresh_overrun)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench one step after an edge, with init_done high; next tick is edge 1.
   task automatic start_run(input logic rd_req, input logic wr_req);
      rst = 1'b1; init_done = 1'b0; app_read_req = 1'b0; app_write_req = 1'b0;
      rd_idle = 1'b0; wr_idle = 1'b0;
      repeat (3) tick();
      rst = 1'b0; init_done = 1'b1; app_read_req = rd_req; app_write_req = wr_req;
   endtask

   initial begin
      rd_command = RDC; rd_address = 12'h5A5; rd_bank = 2'd2;
      wr_command = WRC; wr_address = 12'h0C3; wr_bank = 2'd1;
      rst = 1'b1; init_done = 1'b0; app_read_req = 1'b0; app_write_req = 1'b0;
      rd_idle = 1'b0; wr_idle = 1'b0;

      // reset and init_done low
      repeat (2) tick();
      check("rst_cmd", command, NOP);
      check("rst_addr", address, 0);
      check("rst_bank", bank, 0);
      check("rst_ovr", refresh_overrun, 0);
      rst = 1'b0; app_read_req = 1'b1; app_write_req = 1'b1; rd_idle = 1'b1;
      for (int c = 0; c < 100; c++) begin
         tick();
         check("noinit_cmd", command, NOP);
         check("noinit_rden", rd_enable, 0);
         check("noinit_wren", wr_enable, 0);
         check("noinit_ar", auto_refresh, 0);
      end

      // idle host refresh sequence
      start_run(1'b0, 1'b0);
      repeat (63) tick();
      check("ref_pend_early", auto_refresh, 0);
      for (int c = 64; c <= 77; c++) begin
         tick();
         if (c == 66) begin
            check("ref_pre_cmd", command, PRE);
            check("ref_pre_a10", address, 12'h400);
            check("ref_pre_bank", bank, 0);
         end else if (c == 69) begin
            check("ref_ar_cmd", command, AR);
         end else begin
            check("ref_nop", command, NOP);
         end
         check("ref_pend", auto_refresh, (c >= 64 && c < 69) ? 1 : 0);
      end

      // reset during the AR wait
      start_run(1'b0, 1'b0);
      repeat (71) tick();
      rst = 1'b1;
      tick();
      check("mid_rst_cmd", command, NOP);
      check("mid_rst_ar", auto_refresh, 0);
      rst = 1'b0;
      repeat (63) tick();
      check("mid_rst_timer_early", auto_refresh, 0);
      tick();
      check("mid_rst_timer", auto_refresh, 1);
      tick();
      check("mid_rst_idle_nop", command, NOP);
      tick();
      check("mid_rst_pre", command, PRE);

      // read owner parked for refresh
      start_run(1'b1, 1'b0);
      tick();
      check("rd_grant", rd_enable, 1);
      tick();
      check("rd_pass_cmd", command, RDC);
      check("rd_pass_addr", address, 12'h5A5);
      check("rd_pass_bank", bank, 2);
      repeat (68) tick();
      check("rd_pend", auto_refresh, 1);
      check("rd_wait_cmd", command, RDC);
      rd_idle = 1'b1;
      tick();
      rd_idle = 1'b0;
      check("rd_ref_en71", rd_enable, 1);
      for (int c = 72; c <= 82; c++) begin
         tick();
         check("rd_ref_en", rd_enable, 1);
         check("rd_ref_wren", wr_enable, 0);
         if (c == 72) check("rd_ref_pre", command, PRE);
         else if (c == 75) check("rd_ref_ar", command, AR);
         else check("rd_ref_nop", command, NOP);
      end
      tick();
      check("rd_back_nop", command, NOP);
      check("rd_back_ar", auto_refresh, 0);
      check("rd_back_en", rd_enable, 1);
      tick();
      check("rd_resume", command, RDC);

      // simultaneous requests and round-robin handover
      start_run(1'b1, 1'b1);
      for (int c = 1; c <= 3; c++) begin
         tick();
         check("tie_rden", rd_enable, 1);
         check("tie_wren", wr_enable, 0);
      end
      rd_idle = 1'b1;
      #1;
      check("hand_drop_rd", rd_enable, 0);
      check("hand_drop_wr", wr_enable, 0);
      tick();
      rd_idle = 1'b0;
      #1;
      check("hand_wren", wr_enable, 1);
      check("hand_rden", rd_enable, 0);
      tick();
      check("hand_wr_cmd", command, WRC);
      check("hand_wr_addr", address, 12'h0C3);
      check("hand_excl", rd_enable & wr_enable, 0);
      tick();
      wr_idle = 1'b1;
      #1;
      check("back_drop_wr", wr_enable, 0);
      tick();
      wr_idle = 1'b0;
      #1;
      check("back_rden", rd_enable, 1);
      check("back_wren", wr_enable, 0);

      // refresh overrun when the engine never parks
      start_run(1'b1, 1'b0);
      repeat (127) tick();
      check("ovr_early", refresh_overrun, 0);
      check("ovr_pend", auto_refresh, 1);
      tick();
      check("ovr_set", refresh_overrun, 1);
      repeat (72) tick();
      check("ovr_sticky", refresh_overrun, 1);
      rst = 1'b1;
      tick();
      check("ovr_rst", refresh_overrun, 0);
      check("ovr_rst_en", rd_enable, 0);
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
